// File: rtl/hpdl_bus_monitor.sv
// Display-side monitor for the HPDL-1414 write bus: rebuilds the 16-character
// image from the synchronized pins and can dump it through a UART start/busy handshake.
module hpdl_bus_monitor #(
  parameter int          SYNC_STAGES = 2,
  parameter int          MIN_WR_LOW  = 2,
  parameter logic [7:0]  DUMP_EOL    = 8'h0D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hpdl_d,
  input  logic [1:0] hpdl_a,
  input  logic [3:0] hpdl_wr_n,
  input  logic       dump_req,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic [3:0] rd_addr,
  output logic [6:0] rd_data,
  output logic       wr_event,
  output logic [3:0] wr_pos,
  output logic       bus_err,
  output logic       dump_busy
);

  localparam int             CW        = (MIN_WR_LOW < 1) ? 1 : $clog2(MIN_WR_LOW + 1);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(MIN_WR_LOW);
  localparam logic [12:0]    SYNC_IDLE = {4'hF, 7'h00, 2'b11};

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_HI, WAIT_LO, EOL, EOL_HI, EOL_LO
  } dump_state_t;

  logic [12:0]   sync_q [SYNC_STAGES];
  logic [3:0]    wr_s;
  logic [6:0]    d_s;
  logic [1:0]    a_s;
  logic [3:0]    wr_prev;
  logic [3:0]    low_lines;
  logic [3:0]    lower_low;
  logic [3:0]    blocked;
  logic [CW-1:0] low_cnt [4];
  logic [6:0]    d_held  [4];
  logic [1:0]    a_held  [4];
  logic          multi_low;
  logic          commit_en;
  logic [3:0]    commit_pos;
  logic [6:0]    commit_data;
  logic [3:0]    last_pos;
  logic [6:0]    mem [16];
  dump_state_t   state, state_next;
  logic [3:0]    idx, idx_next;

  // Synchronizers come out of reset at the idle bus levels so no false edge appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= SYNC_IDLE;
    end else begin
      sync_q[0] <= {hpdl_wr_n, hpdl_d, hpdl_a};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign wr_s      = sync_q[SYNC_STAGES-1][12:9];
  assign d_s       = sync_q[SYNC_STAGES-1][8:2];
  assign a_s       = sync_q[SYNC_STAGES-1][1:0];
  assign low_lines = ~wr_s;
  assign multi_low = |(low_lines & (low_lines - 4'd1));

  always_comb begin
    lower_low = '0;
    for (int i = 0; i < 4; i++) lower_low[i] = |(low_lines & ((4'd1 << i) - 4'd1));
  end

  // A line that overlaps a lower-index line is blocked until it returns high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev <= 4'hF;
      blocked <= '0;
      for (int i = 0; i < 4; i++) begin
        low_cnt[i] <= '0;
        d_held[i]  <= '0;
        a_held[i]  <= '0;
      end
    end else begin
      wr_prev <= wr_s;
      for (int i = 0; i < 4; i++) begin
        if (wr_s[i]) begin
          low_cnt[i] <= '0;
          blocked[i] <= 1'b0;
        end else begin
          if (low_cnt[i] != CNT_MAX) low_cnt[i] <= low_cnt[i] + CW'(1);
          if (lower_low[i]) begin
            blocked[i] <= 1'b1;
          end else if (!blocked[i]) begin
            d_held[i] <= d_s;
            a_held[i] <= a_s;
          end
        end
      end
    end
  end

  always_comb begin
    commit_en   = 1'b0;
    commit_pos  = '0;
    commit_data = '0;
    for (int i = 3; i >= 0; i--) begin
      if (wr_s[i] && !wr_prev[i] && (low_cnt[i] >= CNT_MAX) && !blocked[i]) begin
        commit_en   = 1'b1;
        commit_pos  = {2'(i), ~a_held[i]};
        commit_data = d_held[i];
      end
    end
  end

  assign wr_event = commit_en;
  assign wr_pos   = commit_en ? commit_pos : last_pos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < 16; e++) mem[e] <= 7'h20;
      rd_data  <= 7'h20;
      bus_err  <= 1'b0;
      last_pos <= '0;
    end else begin
      if (commit_en) begin
        mem[commit_pos] <= commit_data;
        last_pos        <= commit_pos;
      end
      rd_data <= mem[rd_addr];
      bus_err <= bus_err | multi_low;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (dump_req) begin
          state_next = SEND;
          idx_next   = '0;
        end
      end
      SEND:    if (!tx_busy) state_next = WAIT_HI;
      WAIT_HI: if (tx_busy)  state_next = WAIT_LO;
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == 4'd15) begin
            state_next = EOL;
          end else begin
            idx_next   = idx + 4'd1;
            state_next = SEND;
          end
        end
      end
      EOL:     if (!tx_busy) state_next = EOL_HI;
      EOL_HI:  if (tx_busy)  state_next = EOL_LO;
      EOL_LO:  if (!tx_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Characters are read live from the image at the moment each one is launched.
  always_comb begin
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    dump_busy = (state != IDLE);
    if (state == SEND && !tx_busy) begin
      tx_start = 1'b1;
      tx_data  = {1'b0, mem[idx]};
    end else if (state == EOL && !tx_busy) begin
      tx_start = 1'b1;
      tx_data  = DUMP_EOL;
    end
  end

endmodule
